// File: rtl/rgb_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rgb_sched_pkg                                                    |
// | Shared defaults, state encoding and helpers for the LED scheduler|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package rgb_sched_pkg;

  localparam int LED_NBPC           = 8;
  localparam int LED_SCHED_TICK_DIV = 50000;
  localparam int LED_SCHED_HOLD     = 40;
  localparam int LED_SCHED_GAP      = 10;
  localparam int LED_SCHED_BLINK    = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SHOW = ST_SHOW,
    GAP  = ST_GAP
  } state_t;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | counter                                                          |
// | Modulo up-counter MIN..MAX with synchronous clear; overflow flags|
// | the cycle holding MAX while enabled.                             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module counter #(
  parameter int NBITS = 4,
  parameter int MIN   = 0,
  parameter int MAX   = 15,
  parameter int STEP  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic overflow
);

  logic [NBITS-1:0] r_count;

  assign overflow = en && (r_count == NBITS'(MAX));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= NBITS'(MIN);
    end else if (overflow) begin
      r_count <= NBITS'(MIN);
    end else if (en) begin
      r_count <= r_count + NBITS'(STEP);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rgb_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rgb_sched                                                        |
// | Round-robin time-sharing of the RGB LED between status sources.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rgb_sched
  import rgb_sched_pkg::*;
#(
  parameter int NBPC        = LED_NBPC,
  parameter int NREQ        = 4,
  parameter int TICK_DIV    = LED_SCHED_TICK_DIV,
  parameter int HOLD_TICKS  = LED_SCHED_HOLD,
  parameter int GAP_TICKS   = LED_SCHED_GAP,
  parameter int BLINK_TICKS = LED_SCHED_BLINK
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*3*NBPC-1:0] color,
  input  logic [NREQ-1:0]        blink,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        ack,
  output logic [3*NBPC-1:0]      out_color,
  output logic                   out_en,
  output logic                   busy
);

  localparam int c_colorW = 3 * NBPC;
  localparam int c_ptrW   = $clog2(NREQ);
  localparam int c_tickW  = $clog2(maxOf3(HOLD_TICKS, GAP_TICKS, BLINK_TICKS) + 1);

  // First set request strictly after p, wrapping; iterating downward lets the nearest win.
  function automatic logic [c_ptrW-1:0] rrPick(input logic [NREQ-1:0] r,
                                               input logic [c_ptrW-1:0] p);
    logic [c_ptrW-1:0] idx;
    logic [c_ptrW-1:0] pick;
    pick = p;
    for (int k = NREQ; k >= 1; k--) begin
      idx = c_ptrW'((int'(p) + k) % NREQ);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  state_t               r_state;
  logic [c_ptrW-1:0]    r_ptr;
  logic [c_ptrW-1:0]    r_winner;
  logic [c_colorW-1:0]  r_color;
  logic                 r_blink;
  logic                 r_phase;
  logic [c_tickW-1:0]   r_ticks;
  logic [c_tickW-1:0]   r_blinkCnt;
  logic [NREQ-1:0]      r_grant;
  logic [NREQ-1:0]      r_ack;
  logic [c_colorW-1:0]  r_outColor;
  logic                 r_outEn;
  logic                 r_busy;

  logic                 w_tick;
  logic [c_ptrW-1:0]    w_pick;
  logic [c_colorW-1:0]  w_newColor;
  logic                 w_done;
  logic                 w_drop;
  logic                 w_gapEnd;
  logic                 w_start;
  logic                 w_clr;

  assign w_pick     = rrPick(req, r_ptr);
  assign w_newColor = color[int'(w_pick)*c_colorW +: c_colorW];
  assign w_done     = (r_state == SHOW) && w_tick && (r_ticks == c_tickW'(HOLD_TICKS - 1));
  // Completion on the final tick takes precedence over a simultaneous request drop.
  assign w_drop     = (r_state == SHOW) && !req[r_winner] && !w_done;
  assign w_gapEnd   = (r_state == GAP) && w_tick && (r_ticks == c_tickW'(GAP_TICKS - 1));
  assign w_start    = en && (|req) && ((r_state == IDLE) || w_gapEnd);
  assign w_clr      = !en || (r_state == IDLE) || w_done || w_drop || w_gapEnd;

  counter #(
    .NBITS($clog2(TICK_DIV)),
    .MIN  (0),
    .MAX  (TICK_DIV - 1),
    .STEP (1)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_clr),
    .en      (r_state != IDLE),
    .overflow(w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= c_ptrW'(NREQ - 1);
      r_winner   <= '0;
      r_color    <= '0;
      r_blink    <= 1'b0;
      r_phase    <= 1'b0;
      r_ticks    <= '0;
      r_blinkCnt <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_outColor <= '0;
      r_outEn    <= 1'b0;
      r_busy     <= 1'b0;
    end else if (!en) begin
      r_state    <= IDLE;
      r_ticks    <= '0;
      r_blinkCnt <= '0;
      r_grant    <= '0;
      r_ack      <= '0;
      r_outColor <= '0;
      r_outEn    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ack <= '0;
      if (w_start) begin
        r_state    <= SHOW;
        r_ptr      <= w_pick;
        r_winner   <= w_pick;
        r_color    <= w_newColor;
        r_blink    <= blink[w_pick];
        r_phase    <= 1'b1;
        r_ticks    <= '0;
        r_blinkCnt <= '0;
        r_grant    <= NREQ'(1) << w_pick;
        r_outColor <= w_newColor;
        r_outEn    <= 1'b1;
        r_busy     <= 1'b1;
      end else if (w_gapEnd) begin
        r_state    <= IDLE;
        r_ticks    <= '0;
        r_grant    <= '0;
        r_outColor <= '0;
        r_outEn    <= 1'b0;
        r_busy     <= 1'b0;
      end else if (w_done || w_drop) begin
        r_state    <= GAP;
        r_ticks    <= '0;
        r_grant    <= '0;
        r_outColor <= '0;
        if (w_done) r_ack[r_winner] <= 1'b1;
      end else if (w_tick) begin
        r_ticks <= r_ticks + c_tickW'(1);
        if ((r_state == SHOW) && r_blink) begin
          if (r_blinkCnt == c_tickW'(BLINK_TICKS - 1)) begin
            r_blinkCnt <= '0;
            r_phase    <= ~r_phase;
            r_outColor <= r_phase ? '0 : r_color;
          end else begin
            r_blinkCnt <= r_blinkCnt + c_tickW'(1);
          end
        end
      end
    end
  end

  assign grant     = r_grant;
  assign ack       = r_ack;
  assign out_color = r_outColor;
  assign out_en    = r_outEn;
  assign busy      = r_busy;

endmodule
`default_nettype wire
